capture_packetizer: RTL

Downstream stage of the DataCapture block, running entirely in the slow (read-side) clock domain. Drains captured 16-bit samples from the capture buffer's read port and frames them into byte packets for the host link transmitter.

---
 rtl/fda_link_pkg.sv | 30 +++
 rtl/packet_byte_mux.sv | 72 +++++++
 rtl/capture_packetizer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fda_link_pkg.sv
// Shared definitions for the capture packetizer and the host-link
// transmitter: state encoding, header bytes, packet layout.
package fda_link_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_REQ,
    ST_WAITV,
    ST_SEND_HI,
    ST_SEND_LO,
    ST_CNT,
    ST_CHK
  } state_e;

  localparam logic [7:0] HEADER0_DEF = 8'hAA;
  localparam logic [7:0] HEADER1_DEF = 8'h55;

  // Packet layout: header bytes, two bytes per data word (MSB first),
  // then the trailer (count byte, checksum byte).
  localparam int PKT_HDR_BYTES  = 2;
  localparam int PKT_WORD_BYTES = 2;
  localparam int PKT_TRL_BYTES  = 2;

  function automatic int pkt_len(input int words);
    return PKT_HDR_BYTES + PKT_WORD_BYTES * words + PKT_TRL_BYTES;
  endfunction

endpackage

// File: rtl/packet_byte_mux.sv
// Selects the outgoing byte for each byte state and folds accepted
// data/count bytes into the running XOR checksum.
// Ports: clk, rst (async active-low), state, word, word_cnt,
//        accept (byte taken this cycle), clear (start of packet), tx_data.
module packet_byte_mux
  import fda_link_pkg::*;
#(
  parameter logic [7:0] HEADER0 = HEADER0_DEF,
  parameter logic [7:0] HEADER1 = HEADER1_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  state,
  input  logic [15:0] word,
  input  logic [7:0]  word_cnt,
  input  logic        accept,
  input  logic        clear,
  output logic [7:0]  tx_data
);

  state_e     st;
  logic       folds;
  logic [7:0] csum_q;
  logic [7:0] csum_d;

  assign st = state_e'(state);

  always_comb begin
    tx_data = 8'h00;
    folds   = 1'b0;
    unique case (st)
      ST_HDR0: tx_data = HEADER0;
      ST_HDR1: tx_data = HEADER1;
      ST_SEND_HI: begin
        tx_data = word[15:8];
        folds   = 1'b1;
      end
      ST_SEND_LO: begin
        tx_data = word[7:0];
        folds   = 1'b1;
      end
      ST_CNT: begin
        tx_data = word_cnt;
        folds   = 1'b1;
      end
      ST_CHK: tx_data = csum_q;
      default: begin
        tx_data = 8'h00;
        folds   = 1'b0;
      end
    endcase
  end

  // Headers and the checksum byte itself stay out of the sum.
  always_comb begin
    csum_d = csum_q;
    if (clear) begin
      csum_d = 8'h00;
    end else if (accept && folds) begin
      csum_d = csum_q ^ tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end

endmodule

// File: rtl/capture_packetizer.sv
// Drains 16-bit samples from the capture buffer and frames them into
// byte packets: AA 55 {hi lo}* count checksum over a valid/ready link.
// Ports: clk, rst (async active-low); buffer side dataReadyToRead,
//        dataEmpty, dataValid, dataIn, dataRead; link side txData,
//        txValid, txReady; status busy, timeoutErr (sticky).
module capture_packetizer
  import fda_link_pkg::*;
#(
  parameter int         BURST_WORDS   = 16,
  parameter logic [7:0] HEADER0       = HEADER0_DEF,
  parameter logic [7:0] HEADER1       = HEADER1_DEF,
  parameter int         VALID_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dataReadyToRead,
  input  logic        dataEmpty,
  input  logic        dataValid,
  input  logic [15:0] dataIn,
  output logic        dataRead,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady,
  output logic        busy,
  output logic        timeoutErr
);

  localparam logic [7:0] BURST_LAST = 8'(BURST_WORDS);
  localparam logic [7:0] TMO_LAST   = 8'(VALID_TIMEOUT - 1);

  state_e      state_q;
  state_e      state_d;
  logic [15:0] word_q;
  logic [15:0] word_d;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic [7:0]  cnt_inc;
  logic [7:0]  tmo_q;
  logic [7:0]  tmo_d;
  logic        terr_q;
  logic        terr_d;
  logic        clear;
  logic        accept;

  assign accept     = txValid & txReady;
  assign busy       = (state_q != ST_IDLE);
  assign timeoutErr = terr_q;
  assign cnt_inc    = cnt_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    terr_d   = terr_q;
    clear    = 1'b0;
    dataRead = 1'b0;
    txValid  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (dataReadyToRead && !dataEmpty) begin
          state_d = ST_HDR0;
          cnt_d   = 8'd0;
          clear   = 1'b1;
        end
      end
      ST_HDR0: begin
        txValid = 1'b1;
        if (txReady) state_d = ST_HDR1;
      end
      ST_HDR1: begin
        txValid = 1'b1;
        if (txReady) state_d = ST_REQ;
      end
      ST_REQ: begin
        dataRead = 1'b1;
        tmo_d    = 8'd0;
        state_d  = ST_WAITV;
      end
      ST_WAITV: begin
        // A word arriving on the last allowed cycle still wins.
        if (dataValid) begin
          word_d  = dataIn;
          state_d = ST_SEND_HI;
        end else if (tmo_q == TMO_LAST) begin
          terr_d  = 1'b1;
          state_d = ST_CNT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_SEND_HI: begin
        txValid = 1'b1;
        if (txReady) state_d = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        txValid = 1'b1;
        if (txReady) begin
          cnt_d = cnt_inc;
          if ((cnt_inc == BURST_LAST) || dataEmpty) begin
            state_d = ST_CNT;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_CNT: begin
        txValid = 1'b1;
        if (txReady) state_d = ST_CHK;
      end
      ST_CHK: begin
        txValid = 1'b1;
        if (txReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      word_q  <= 16'h0000;
      cnt_q   <= 8'd0;
      tmo_q   <= 8'd0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      terr_q  <= terr_d;
    end
  end

  packet_byte_mux #(
    .HEADER0 (HEADER0),
    .HEADER1 (HEADER1)
  ) u_mux (
    .clk      (clk),
    .rst      (rst),
    .state    (state_q),
    .word     (word_q),
    .word_cnt (cnt_q),
    .accept   (accept),
    .clear    (clear),
    .tx_data  (txData)
  );

endmodule
